// File: rtl/sensor_sampler.sv
// Multi-bit sensor front end: two-flop synchronizer, per-bit debounce counters,
// and a registered debounced word with an update strobe and running update count.
module sensor_sampler #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sensor_raw,
    input  logic             enable,
    output logic [WIDTH-1:0] xin_out,
    output logic             xin_valid,
    output logic [7:0]       change_count
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] accept;
    logic             any_accept;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; sync2 must see the old sync1, not the one just written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sensor_raw;
            sync2 <= sync1;
        end
    end

    // NOTE: every variable gets a default before any conditional write, so no
    // latch is inferred for bits the loop might otherwise leave unassigned.
    always_comb begin
        differ = sync2 ^ xin_out;
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = enable && differ[i] && (cnt[i] == CNT_LAST);
        end
    end

    assign any_accept = |accept;

    // NOTE: cnt is an array of per-bit flops, not a RAM; it must be reset because
    // a stale partial count would shorten the next debounce window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!enable || !differ[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Accepted bits take their synchronized value; all others hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xin_out      <= '0;
            xin_valid    <= 1'b0;
            change_count <= 8'd0;
        end else begin
            xin_out   <= (xin_out & ~accept) | (sync2 & accept);
            xin_valid <= any_accept;
            if (any_accept) begin
                change_count <= change_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/sensor_sampler.md
SENSOR_SAMPLER -- requirements
Module: sensor_sampler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of sensor bits.
REQ-002 The block SHALL have parameter DB_CYCLES, default 4, legal range 1..255, giving the consecutive-cycle debounce threshold.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port sensor_raw, input, WIDTH bits, the asynchronous raw sensor lines.
REQ-006 The block SHALL have port enable, input, 1 bit, which allows debounce progress when high.
REQ-007 The block SHALL have port xin_out, output, WIDTH bits, the debounced sensor word that feeds the downstream combinational function stage.
REQ-008 The block SHALL have port xin_valid, output, 1 bit, a one-cycle pulse marking a new xin_out value.
REQ-009 The block SHALL have port change_count, output, 8 bits, a running count of xin_out updates.

Function
REQ-010 Each sensor_raw bit SHALL pass through a two-flop synchronizer: sync1 captures raw, then sync2 captures sync1.
- No other logic reads sync1.
REQ-011 Each bit SHALL have its own debounce counter, ceil(log2(DB_CYCLES)) bits wide (minimum 1).
REQ-012 At each edge with enable=1, if sync2[i] != xin_out[i], the block SHALL:
- set xin_out[i] <= sync2[i] and cnt[i] <= 0 when cnt[i] == DB_CYCLES-1;
- otherwise set cnt[i] <= cnt[i]+1.
REQ-013 At each edge with enable=1, if sync2[i] == xin_out[i], the block SHALL set cnt[i] <= 0.
- A glitch shorter than DB_CYCLES sync2 samples never reaches xin_out.
REQ-014 Latency SHALL be exactly 2+DB_CYCLES rising edges from a raw change that is stable before edge 1 to the xin_out change.
- Example: 6 edges when DB_CYCLES=4.
REQ-015 With DB_CYCLES=1, a differing sync2 value SHALL be accepted at the first edge that samples it.
REQ-016 xin_valid SHALL be registered and high for exactly the one cycle in which xin_out first holds a new value.
- Otherwise xin_valid is low.
REQ-017 When several bits update at the same edge, the block SHALL produce one xin_valid pulse and one change_count increment.
REQ-018 Bits SHALL debounce independently: a bit reaching threshold updates even while other bits are mid-count.
REQ-019 change_count SHALL increment by 1 at each edge where xin_valid is set, wrapping 255 -> 0 without saturation.
REQ-020 While enable=0:
- synchronizers SHALL keep running;
- all debounce counters SHALL be held at 0;
- xin_out and change_count SHALL hold;
- xin_valid SHALL be 0.
REQ-021 When enable returns high, debounce SHALL restart from count 0.
- Any sync2/xin_out mismatch then needs a full DB_CYCLES samples.
REQ-022 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-023 While rst_n=0, sync1, sync2, all counters, xin_out, xin_valid and change_count SHALL be 0, asynchronously to clk.
REQ-024 Reset assertion mid-debounce SHALL discard partial counts.
- No xin_valid pulse is generated for the interrupted transition.
REQ-025 After rst_n deasserts, normal operation SHALL begin at the next rising edge.
- A nonzero sensor_raw held through reset appears on xin_out at edge 2+DB_CYCLES after release, with one xin_valid pulse.

Verification
REQ-026 Bench SHALL check this case (DB_CYCLES=4, enable=1): raw 0x0 -> 0x5 just before edge 1 -> xin_out=0x5 and xin_valid=1 after edge 6 only, change_count=1.
REQ-027 Bench SHALL check this case: raw bit0 pulsed high for 3 cycles then low -> xin_out stays 0x0, no xin_valid, change_count unchanged.
REQ-028 Bench SHALL check this case: raw 0x0 -> 0xF on all bits simultaneously -> a single xin_valid pulse at edge 6, change_count +1.
REQ-029 Bench SHALL check this case: enable=0 during a raw 0x0 -> 0x3 change, enable=1 ten cycles later -> xin_out=0x3 at the 4th edge after enable rises, held at 0x0 before.
REQ-030 Bench SHALL check this case: rst_n pulsed low at edge 4 of a 0x0 -> 0x8 debounce -> all outputs 0 immediately; with raw still 0x8, xin_out=0x8 at edge 6 after release.
REQ-031 Bench SHALL check this case: 256 alternating 0x0/0x1 transitions, each held 8 cycles -> change_count wraps to 0, one xin_valid per transition.
